// File: rtl/meas_mode_ctrl.sv
// rtl/meas_mode_ctrl.sv - keypad-driven measurement-mode and gate-time controller
//
// Turns qualified keypad presses into measurement mode, gate length and a
// commit pulse for the counter datapath, and multiplexes a two-digit status
// display (mode, gate steps).
//
// Optional feature macro: GATE_AUTOREPEAT_EN
//   defined   - holding gate up/down (4'hA / 4'hB) auto-repeats the step
//   undefined - exactly one step per press, no repeat timer
//
// Ports:
//   sys_clk        in   system clock
//   sys_rst_n      in   asynchronous active-low reset
//   key_valid      in   key held indication from the scanner
//   key_value[3:0] in   key code, stable while key_valid is high
//   mode[3:0]      out  active mode 1..N_MODES, or 4'hA for ADJ
//   gate_steps[3:0]out  gate length in steps
//   key_gate_time  out  gate_steps*GATE_STEP
//   key_time_max   out  key_gate_time+TIMEOUT_EXTRA
//   renew          out  one-cycle commit/restart pulse
//   seg_sel[7:0]   out  active-low digit select
//   seg_led[7:0]   out  active-low segments, bit 7 is dp

module meas_mode_ctrl #(
    parameter int N_MODES       = 3,
    parameter int CNT_W         = 30,
    parameter int GATE_STEP     = 50_000_000,
    parameter int GATE_MIN      = 1,
    parameter int GATE_MAX      = 10,
    parameter int TIMEOUT_EXTRA = 10_000_000,
    parameter int PRESS_QUAL    = 3,
    parameter int SCAN_DIV      = 50_000,
    parameter int REPEAT_DLY    = 25_000_000,
    parameter int REPEAT_PER    = 10_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             key_valid,
    input  logic [3:0]       key_value,
    output logic [3:0]       mode,
    output logic [3:0]       gate_steps,
    output logic [CNT_W-1:0] key_gate_time,
    output logic [CNT_W-1:0] key_time_max,
    output logic             renew,
    output logic [7:0]       seg_sel,
    output logic [7:0]       seg_led
);

    localparam logic [3:0] MODE_ADJ = 4'hA;
    localparam logic [3:0] KEY_UP   = 4'hA;
    localparam logic [3:0] KEY_DN   = 4'hB;
    localparam logic [3:0] KEY_RST  = 4'h0;

    localparam longint TM_LARGEST = longint'(GATE_MAX) * longint'(GATE_STEP)
                                  + longint'(TIMEOUT_EXTRA);
    localparam longint CNT_LIMIT  = longint'(1) << CNT_W;

    localparam logic [CNT_W-1:0] GT_STEP = CNT_W'(GATE_STEP);
    localparam logic [CNT_W-1:0] GT_MIN  = CNT_W'(longint'(GATE_MIN) * longint'(GATE_STEP));
    localparam logic [CNT_W-1:0] GT_MAX  = CNT_W'(longint'(GATE_MAX) * longint'(GATE_STEP));
    localparam logic [CNT_W-1:0] TM_MIN  = CNT_W'(longint'(GT_MIN) + longint'(TIMEOUT_EXTRA));
    localparam logic [CNT_W-1:0] TM_MAX  = CNT_W'(TM_LARGEST);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Elaboration-time parameter sanity checks.
    if (TM_LARGEST >= CNT_LIMIT) begin : g_chk_cnt_w
        $error("meas_mode_ctrl: GATE_MAX*GATE_STEP+TIMEOUT_EXTRA does not fit CNT_W");
    end
    if (N_MODES < 1 || N_MODES > 9) begin : g_chk_modes
        $error("meas_mode_ctrl: N_MODES out of range 1..9");
    end
    if (GATE_MIN < 1 || GATE_MAX < GATE_MIN || GATE_MAX > 15) begin : g_chk_gate
        $error("meas_mode_ctrl: gate step range illegal");
    end
    if (PRESS_QUAL < 1 || SCAN_DIV < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_chk_timing
        $error("meas_mode_ctrl: timing parameters must be positive");
    end

    // ---------------------------------------------------------------
    // Press qualifier: oldest sample low, all newer samples high.
    // ---------------------------------------------------------------
    logic [PRESS_QUAL:0] key_sr_q, key_sr_d;
    logic                key_pose;

    assign key_sr_d = {key_sr_q[PRESS_QUAL-1:0], key_valid};
    assign key_pose = ~key_sr_q[PRESS_QUAL] & (&key_sr_q[PRESS_QUAL-1:0]);

    // ---------------------------------------------------------------
    // Repeat timer (synthetic gate up/down events while held)
    // ---------------------------------------------------------------
    logic rep_fire;

`ifdef GATE_AUTOREPEAT_EN
    logic [31:0] rep_cnt_q, rep_cnt_d;
    logic        rep_act_q, rep_act_d;
    logic        rep_first_q, rep_first_d;
    logic [3:0]  rep_code_q, rep_code_d;

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_act_d   = rep_act_q;
        rep_first_d = rep_first_q;
        rep_code_d  = rep_code_q;
        rep_fire    = 1'b0;
        if (key_pose && (key_value == KEY_UP || key_value == KEY_DN)) begin
            rep_act_d   = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
            rep_code_d  = key_value;
        end else if (rep_act_q) begin
            if (!key_valid || key_value != rep_code_q) begin
                rep_act_d = 1'b0;
                rep_cnt_d = '0;
            end else if (rep_first_q ? (rep_cnt_q == 32'(REPEAT_DLY - 1))
                                     : (rep_cnt_q == 32'(REPEAT_PER - 1))) begin
                rep_fire    = 1'b1;
                rep_first_d = 1'b0;
                rep_cnt_d   = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rep_cnt_q   <= '0;
            rep_act_q   <= 1'b0;
            rep_first_q <= 1'b0;
            rep_code_q  <= '0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_act_q   <= rep_act_d;
            rep_first_q <= rep_first_d;
            rep_code_q  <= rep_code_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Event decode, mode and gate state
    // ---------------------------------------------------------------
    logic             key_evt;
    logic [3:0]       mode_q, mode_d;
    logic [3:0]       prev_mode_q, prev_mode_d;
    logic [3:0]       steps_q, steps_d;
    logic [CNT_W-1:0] gate_time_q, gate_time_d;
    logic [CNT_W-1:0] time_max_q, time_max_d;
    logic             renew_q, renew_d;

    assign key_evt = key_pose | rep_fire;

    always_comb begin
        mode_d      = mode_q;
        prev_mode_d = prev_mode_q;
        steps_d     = steps_q;
        gate_time_d = gate_time_q;
        time_max_d  = time_max_q;
        renew_d     = 1'b0;
        if (key_evt) begin
            if (key_value >= 4'd1 && key_value <= 4'(N_MODES)) begin
                prev_mode_d = mode_q;
                mode_d      = key_value;
            end else if (key_value == KEY_UP || key_value == KEY_DN) begin
                // Staying in ADJ keeps the mode to restore untouched.
                if (mode_q != MODE_ADJ) begin
                    prev_mode_d = mode_q;
                end
                mode_d = MODE_ADJ;
                if (key_value == KEY_UP) begin
                    if (steps_q == 4'(GATE_MAX)) begin
                        steps_d     = 4'(GATE_MIN);
                        gate_time_d = GT_MIN;
                        time_max_d  = TM_MIN;
                    end else begin
                        steps_d     = steps_q + 4'd1;
                        gate_time_d = gate_time_q + GT_STEP;
                        time_max_d  = time_max_q + GT_STEP;
                    end
                end else begin
                    if (steps_q == 4'(GATE_MIN)) begin
                        steps_d     = 4'(GATE_MAX);
                        gate_time_d = GT_MAX;
                        time_max_d  = TM_MAX;
                    end else begin
                        steps_d     = steps_q - 4'd1;
                        gate_time_d = gate_time_q - GT_STEP;
                        time_max_d  = time_max_q - GT_STEP;
                    end
                end
            end else if (key_value == KEY_RST) begin
                mode_d      = prev_mode_q;
                prev_mode_d = 4'd1;
                renew_d     = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Display multiplexer
    // ---------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            4'hA:    seg7 = 7'h08;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic              digit_q, digit_d;
    logic [7:0]        seg_sel_q, seg_sel_d;
    logic [7:0]        seg_led_q, seg_led_d;
    logic              scan_tc;
    logic [3:0]        steps_ones;

    assign scan_tc    = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign steps_ones = (steps_d >= 4'd10) ? (steps_d - 4'd10) : steps_d;

    // Segments are built from next-state values so the registered pattern
    // always matches the registered mode/steps in the same cycle.
    always_comb begin
        scan_cnt_d = scan_tc ? '0 : scan_cnt_q + SCAN_W'(1);
        digit_d    = digit_q ^ scan_tc;
        seg_sel_d  = digit_d ? 8'b1011_1111 : 8'b0111_1111;
        if (digit_d) begin
            seg_led_d = {~(steps_d >= 4'd10), seg7(steps_ones)};
        end else begin
            seg_led_d = {1'b1, seg7(mode_d)};
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_sr_q    <= '0;
            mode_q      <= 4'd1;
            prev_mode_q <= 4'd1;
            steps_q     <= 4'(GATE_MIN);
            gate_time_q <= GT_MIN;
            time_max_q  <= TM_MIN;
            renew_q     <= 1'b0;
            scan_cnt_q  <= '0;
            digit_q     <= 1'b0;
            seg_sel_q   <= 8'b0111_1111;
            seg_led_q   <= 8'b1111_1001;
        end else begin
            key_sr_q    <= key_sr_d;
            mode_q      <= mode_d;
            prev_mode_q <= prev_mode_d;
            steps_q     <= steps_d;
            gate_time_q <= gate_time_d;
            time_max_q  <= time_max_d;
            renew_q     <= renew_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            seg_sel_q   <= seg_sel_d;
            seg_led_q   <= seg_led_d;
        end
    end

    assign mode          = mode_q;
    assign gate_steps    = steps_q;
    assign key_gate_time = gate_time_q;
    assign key_time_max  = time_max_q;
    assign renew         = renew_q;
    assign seg_sel       = seg_sel_q;
    assign seg_led       = seg_led_q;

endmodule

// File: tb/tb_meas_mode_ctrl.sv
// tb/tb_meas_mode_ctrl.sv - randomized self-checking bench for meas_mode_ctrl

module tb_meas_mode_ctrl;

    localparam int N_MODES    = 3;
    localparam int CNT_W      = 30;
    localparam int GATE_STEP  = 50_000_000;
    localparam int GATE_MIN   = 1;
    localparam int GATE_MAX   = 10;
    localparam int TO_EXTRA   = 10_000_000;
    localparam int PQ         = 3;
    localparam int SCAN       = 8;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             key_valid;
    logic [3:0]       key_value;
    logic [3:0]       mode;
    logic [3:0]       gate_steps;
    logic [CNT_W-1:0] key_gate_time;
    logic [CNT_W-1:0] key_time_max;
    logic             renew;
    logic [7:0]       seg_sel;
    logic [7:0]       seg_led;

    meas_mode_ctrl #(
        .N_MODES(N_MODES), .CNT_W(CNT_W), .GATE_STEP(GATE_STEP),
        .GATE_MIN(GATE_MIN), .GATE_MAX(GATE_MAX), .TIMEOUT_EXTRA(TO_EXTRA),
        .PRESS_QUAL(PQ), .SCAN_DIV(SCAN)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .key_valid(key_valid), .key_value(key_value),
        .mode(mode), .gate_steps(gate_steps),
        .key_gate_time(key_gate_time), .key_time_max(key_time_max),
        .renew(renew), .seg_sel(seg_sel), .seg_led(seg_led)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: mode/steps as plain integers, gate values by multiplication.
    int m_mode, m_prev, m_steps;

    function automatic void model_reset();
        m_mode  = 1;
        m_prev  = 1;
        m_steps = GATE_MIN;
    endfunction

    function automatic void model_evt(input int k);
        if (k >= 1 && k <= N_MODES) begin
            m_prev = m_mode;
            m_mode = k;
        end else if (k == 10 || k == 11) begin
            if (m_mode != 10) m_prev = m_mode;
            m_mode = 10;
            if (k == 10) m_steps = (m_steps == GATE_MAX) ? GATE_MIN : m_steps + 1;
            else         m_steps = (m_steps == GATE_MIN) ? GATE_MAX : m_steps - 1;
        end else if (k == 0) begin
            m_mode = m_prev;
            m_prev = 1;
        end
    endfunction

    function automatic logic [7:0] exp_digit(input int v, input logic dp_on);
        logic [6:0] s;
        case (v)
            0: s = 7'b1000000;  1: s = 7'b1111001;  2: s = 7'b0100100;
            3: s = 7'b0110000;  4: s = 7'b0011001;  5: s = 7'b0010010;
            6: s = 7'b0000010;  7: s = 7'b1111000;  8: s = 7'b0000000;
            9: s = 7'b0010000;  10: s = 7'b0001000;
            default: s = 7'b1111111;
        endcase
        return {~dp_on, s};
    endfunction

    function automatic logic [7:0] exp_led(input logic [7:0] sel);
        if (sel == 8'b0111_1111) return exp_digit(m_mode, 1'b0);
        if (sel == 8'b1011_1111) return exp_digit(m_steps % 10, m_steps >= 10);
        return 8'h00;
    endfunction

    int         renew_seen;
    logic [3:0] mode_at_renew;

    task automatic cyc();
        @(posedge sys_clk);
        #1;
        if (renew) begin
            renew_seen++;
            mode_at_renew = mode;
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_mode"}, 64'(mode), 64'(m_mode));
        check_eq({tag, "_steps"}, 64'(gate_steps), 64'(m_steps));
        check_eq({tag, "_gate"}, 64'(key_gate_time), 64'(m_steps) * 64'(GATE_STEP));
        check_eq({tag, "_tmax"}, 64'(key_time_max), 64'(m_steps) * 64'(GATE_STEP) + 64'(TO_EXTRA));
    endtask

    task automatic press(input string tag, input logic [3:0] k, input int len, input int gap);
        logic qual;
        renew_seen = 0;
        key_value  = k;
        key_valid  = 1'b1;
        repeat (len) cyc();
        key_valid = 1'b0;
        repeat (gap) cyc();
        qual = (len >= PQ);
        if (qual) model_evt(int'(k));
        check_state(tag);
        check_eq({tag, "_renew_cnt"}, 64'(renew_seen), (qual && k == 4'h0) ? 64'd1 : 64'd0);
        if (qual && k == 4'h0 && renew_seen == 1)
            check_eq({tag, "_renew_mode"}, 64'(mode_at_renew), 64'(m_mode));
    endtask

    task automatic check_display();
        logic [7:0] sel0;
        int         t;
        logic [7:0] led_bad;
        sel0 = seg_sel;
        t = 0;
        while (seg_sel == sel0 && t < 4 * SCAN) begin cyc(); t++; end
        check_eq("disp_toggle_seen", 64'(seg_sel != sel0), 64'd1);
        for (int d = 0; d < 2; d++) begin
            sel0    = seg_sel;
            led_bad = 8'h00;
            t       = 0;
            check_eq("disp_led", 64'(seg_led), 64'(exp_led(seg_sel)));
            while (seg_sel == sel0 && t < 4 * SCAN) begin
                if (seg_led != exp_led(seg_sel)) led_bad = seg_led;
                cyc();
                t++;
            end
            check_eq("disp_dwell", 64'(t), 64'(SCAN));
            check_eq("disp_stable", 64'(led_bad), 64'd0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_state(tag);
        check_eq({tag, "_renew"}, 64'(renew), 64'd0);
        check_eq({tag, "_sel"}, 64'(seg_sel), 64'h7F);
        check_eq({tag, "_led"}, 64'(seg_led), 64'hF9);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n = 1'b0;
        key_valid = 1'b0;
        key_value = 4'h0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_vals("reset");
        sys_rst_n = 1'b1;
        cyc();

        // Mode select, gate stepping and commit.
        press("key2", 4'h2, 4, 2);
        for (int i = 0; i < 3; i++) press("up", 4'hA, 3, 2);
        check_eq("gate_after_3up", 64'(key_gate_time), 64'd200_000_000);
        press("restore", 4'h0, 5, 1);
        check_eq("restore_mode2", 64'(mode), 64'd2);

        // Wrap in both directions.
        for (int i = 0; i < 6; i++) press("up_to_max", 4'hA, 3, 1);
        check_eq("at_max", 64'(gate_steps), 64'd10);
        check_display();
        press("wrap_up", 4'hA, 3, 2);
        check_eq("wrap_up_tmax", 64'(key_time_max), 64'd60_000_000);
        press("wrap_dn", 4'hB, 3, 2);
        check_eq("wrap_dn_gate", 64'(key_gate_time), 64'd500_000_000);

        // Glitch and out-of-range mode key.
        press("glitch", 4'h1, 2, 2);
        press("key5", 4'h5, 4, 2);
        check_display();

        // Reset just after a qualified event.
        key_value = 4'hA;
        key_valid = 1'b1;
        repeat (PQ + 1) cyc();
        model_evt(10);
        check_state("pre_rst");
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_vals("mid_rst");
        renew_seen = 0;
        repeat (2) cyc();
        check_eq("mid_rst_no_renew", 64'(renew_seen), 64'd0);
        // Key still held across reset release: needs PQ fresh samples.
        sys_rst_n = 1'b1;
        repeat (PQ) cyc();
        check_state("held_pre");
        cyc();
        model_evt(10);
        check_state("held_post");
        key_valid = 1'b0;
        cyc();

        // Randomized presses against the model.
        for (int i = 0; i < 60; i++) begin
            press("rnd", 4'($urandom_range(0, 15)), int'($urandom_range(1, 6)),
                  int'($urandom_range(1, 3)));
        end
        check_display();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
